// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NumReq valid/ready requesters.
// Latency: grant in T, tx_start_o pulse in T+1, WAIT from T+2 until tx_done_tick_i.
// Backpressure: req_ready_o only in IDLE; optional watchdog under UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NumReq        = 4,
  parameter int WordLength    = 8,
  parameter int TimeoutCycles = 200_000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumReq-1:0]            req_valid_i,
  input  logic [NumReq*WordLength-1:0] req_data_i,
  output logic [NumReq-1:0]            req_ready_o,
  output logic [WordLength-1:0]        tx_din_o,
  output logic                         tx_start_o,
  input  logic                         tx_done_tick_i,
  output logic [$clog2(NumReq)-1:0]    grant_id_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int IdW = $clog2(NumReq);
  localparam logic [NumReq-1:0] OneHot0 = NumReq'(1);

  if (NumReq < 2 || NumReq > 16) begin : g_bad_num_req
    $error("uart_tx_arbiter: NumReq must be in 2..16");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TimeoutCycles must be at least 2");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT} state_t;

  state_t                state;
  logic                  any_vld;
  logic [IdW-1:0]        winner;
  logic [IdW-1:0]        cand;
  logic [WordLength-1:0] req_data [NumReq];

  for (genvar i = 0; i < NumReq; i++) begin : g_unpack
    assign req_data[i] = req_data_i[i*WordLength +: WordLength];
  end

  // grant_id_o doubles as the round-robin pointer: search starts just after it
  always_comb begin
    any_vld = 1'b0;
    winner  = grant_id_o;
    cand    = '0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = IdW'((int'(grant_id_o) + k) % NumReq);
      if (!any_vld && req_valid_i[cand]) begin
        any_vld = 1'b1;
        winner  = cand;
      end
    end
  end

  assign req_ready_o = (rst_ni && state == ST_IDLE && any_vld) ? (OneHot0 << winner) : '0;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      tx_din_o   <= '0;
      tx_start_o <= 1'b0;
      grant_id_o <= IdW'(NumReq - 1);
      busy_o     <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_cnt     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      tx_start_o <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (any_vld) begin
            tx_din_o   <= req_data[winner];
            grant_id_o <= winner;
            tx_start_o <= 1'b1;
            busy_o     <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          // a done tick on the limit cycle wins over the watchdog
          if (tx_done_tick_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (wd_cnt == 32'(TimeoutCycles - 1)) begin
            state     <= ST_IDLE;
            busy_o    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter; expected grants come from a round-robin model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   req_valid_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_ready_o;
  logic [W-1:0]   tx_din_o;
  logic           tx_start_o;
  logic           tx_done_tick_i;
  logic [1:0]     grant_id_o;
  logic           busy_o;
  logic           timeout_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           id;
    logic [W-1:0] dat;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [N-1:0] pend_vld;
  logic [W-1:0] pend_dat [N];
  int           last_gnt;

  always #5 clk_i = ~clk_i;

  uart_tx_arbiter #(.NumReq(N), .WordLength(W), .TimeoutCycles(TO)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_data_i     (req_data_i),
    .req_ready_o    (req_ready_o),
    .tx_din_o       (tx_din_o),
    .tx_start_o     (tx_start_o),
    .tx_done_tick_i (tx_done_tick_i),
    .grant_id_o     (grant_id_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner = first pending requester in the order last+1, last+2, ... wrapping, last itself at the end
  function automatic int rr_pick(input int last, input logic [N-1:0] p);
    for (int k = 1; k <= N; k++) begin
      if (p[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Monitor: every start pulse must match the oldest expected grant
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      check("ready_onehot0", 32'($onehot0(req_ready_o)), 32'd1);
      if (tx_start_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got start for id %0d, expected none at %0t", grant_id_o, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("grant_id", 32'(grant_id_o), 32'(mon_e.id));
          check("tx_din", 32'(tx_din_o), 32'(mon_e.dat));
        end
      end
    end
  end

  task automatic drive();
    req_valid_i = pend_vld;
    for (int i = 0; i < N; i++) req_data_i[i*W +: W] = pend_dat[i];
  endtask

  // mode 0: none, 1: random idle requesters raise valid, 2: every idle requester raises valid
  task automatic add_reqs(input int mode);
    for (int i = 0; i < N; i++) begin
      if (!pend_vld[i] && mode != 0 && (mode == 2 || $urandom_range(0, 1) == 1)) begin
        pend_vld[i] = 1'b1;
        pend_dat[i] = W'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tx_done_tick_i = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_din", 32'(tx_din_o), 32'd0);
    check("rst_start", 32'(tx_start_o), 32'd0);
    check("rst_grant_id", 32'(grant_id_o), 32'(N - 1));
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_gnt = N - 1;
  endtask

  // Called at a negedge with the DUT idle. d>0: done tick d cycles into WAIT; d==0: never.
  task automatic serve(input int d, input bit stray, input int add_mode, input int abort_at);
    int w;
    if (pend_vld == '0) add_reqs(2);
    w = rr_pick(last_gnt, pend_vld);
    exp_q.push_back('{w, pend_dat[w]});
    drive();
    #1;
    check("ready_grant", 32'(req_ready_o), 32'd1 << w);
    @(negedge clk_i);
    check("busy_start", 32'(busy_o), 32'd1);
    pend_vld[w] = 1'b0;
    last_gnt = w;
    add_reqs(add_mode);
    drive();
    tx_done_tick_i = stray;
    if (abort_at > 0) begin
      @(negedge clk_i);
      tx_done_tick_i = 1'b0;
      repeat (abort_at - 1) @(negedge clk_i);
      do_reset();
    end else if (d == 0) begin
`ifdef UART_TX_ARB_TIMEOUT_EN
      for (int k = 1; k <= TO; k++) begin
        @(negedge clk_i);
        tx_done_tick_i = 1'b0;
        check("busy_wd", 32'(busy_o), 32'd1);
        check("timeout_early", 32'(timeout_o), 32'd0);
      end
      @(negedge clk_i);
      check("timeout_pulse", 32'(timeout_o), 32'd1);
      check("busy_after_timeout", 32'(busy_o), 32'd0);
`else
      for (int k = 1; k <= 2 * TO; k++) begin
        @(negedge clk_i);
        tx_done_tick_i = 1'b0;
        check("busy_stall", 32'(busy_o), 32'd1);
        check("timeout_tied", 32'(timeout_o), 32'd0);
      end
      tx_done_tick_i = 1'b1;
      @(negedge clk_i);
      tx_done_tick_i = 1'b0;
      check("busy_after_stall", 32'(busy_o), 32'd0);
`endif
    end else begin
      for (int k = 1; k <= d; k++) begin
        @(negedge clk_i);
        tx_done_tick_i = (k == d);
        check("busy_wait", 32'(busy_o), 32'd1);
        if (k == 1) check("ready_in_wait", 32'(req_ready_o), 32'd0);
      end
      @(negedge clk_i);
      tx_done_tick_i = 1'b0;
      check("busy_done", 32'(busy_o), 32'd0);
      check("timeout_done", 32'(timeout_o), 32'd0);
    end
  endtask

  task automatic idle_stray();
    drive();
    tx_done_tick_i = 1'b1;
    @(negedge clk_i);
    tx_done_tick_i = 1'b0;
    check("idle_stray_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    check("idle_stray_busy2", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not reach its end, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int d;
    rst_ni = 1'b0;
    req_valid_i = '0;
    req_data_i = '0;
    tx_done_tick_i = 1'b0;
    pend_vld = '0;
    for (int i = 0; i < N; i++) pend_dat[i] = '0;
    last_gnt = N - 1;
    @(negedge clk_i);
    do_reset();

    // single requester 1 with 0xA5
    pend_vld[1] = 1'b1;
    pend_dat[1] = 8'hA5;
    serve(10, 1'b0, 0, 0);

    // req 2 served, then req 2 and 3 together: 3 first, then 2
    pend_vld[2] = 1'b1;
    pend_dat[2] = 8'h22;
    serve(3, 1'b0, 0, 0);
    pend_vld[2] = 1'b1;
    pend_dat[2] = 8'h5A;
    pend_vld[3] = 1'b1;
    pend_dat[3] = 8'h3C;
    serve(4, 1'b0, 0, 0);
    serve(2, 1'b0, 0, 0);

    // stray done ticks in IDLE and START
    idle_stray();
    pend_vld[0] = 1'b1;
    pend_dat[0] = 8'h81;
    serve(5, 1'b1, 0, 0);

    // reset mid-WAIT with everyone pending, then all held valid: 0,1,2,3,0
    pend_vld[1] = 1'b1;
    pend_dat[1] = 8'h11;
    serve(10, 1'b0, 2, 4);
    for (int r = 0; r < 5; r++) serve(10, 1'b0, 2, 0);

    // watchdog (or indefinite wait without it), then a done tick exactly on the limit
    serve(0, 1'b0, 0, 0);
    serve(TO, 1'b0, 0, 0);

    for (int r = 0; r < 40; r++) begin
      if (pend_vld == '0 && $urandom_range(0, 2) == 0) idle_stray();
      add_reqs(1);
      d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO);
      serve(d, 1'($urandom_range(0, 1)), $urandom_range(0, 1),
            ($urandom_range(0, 19) == 0) ? $urandom_range(1, 5) : 0);
    end

    pend_vld = '0;
    drive();
    repeat (3) @(negedge clk_i);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
